// File: rtl/bp_host_io_initiator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_host_io_initiator_pkg: HIO op codes, host address map, BedRock mem message
// Revision: 1.0
// ----------------------------------------------------------------------------
package bp_host_io_initiator_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 128;
  localparam int hio_data_width_p  = 64;

  function automatic int cfg_num_core(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? 4 : 1;
  endfunction

  typedef enum logic [3:0] {
    e_hio_putchar      = 4'd0,
    e_hio_putchar_core = 4'd1,
    e_hio_getchar      = 4'd2,
    e_hio_finish       = 4'd3,
    e_hio_trace_en_0   = 4'd4,
    e_hio_trace_en_1   = 4'd5,
    e_hio_trace_en_2   = 4'd6,
    e_hio_trace_en_3   = 4'd7,
    e_hio_trace_en_4   = 4'd8,
    e_hio_trace_en_5   = 4'd9,
    e_hio_trace_en_6   = 4'd10,
    e_hio_trace_en_7   = 4'd11,
    e_hio_trace_en_8   = 4'd12,
    e_hio_trace_en_9   = 4'd13
  } bp_hio_op_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [7:0]               payload;
    bp_bedrock_msg_size_e     size;
    logic [paddr_width_p-1:0] addr;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_bedrock_mem_header_s       header;
  } bp_bedrock_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_bedrock_cce_mem_msg_s);

  localparam logic [paddr_width_p-1:0] hio_getchar_addr_gp      = 40'h00_0010_0000;
  localparam logic [paddr_width_p-1:0] hio_putchar_addr_gp      = 40'h00_0010_1000;
  localparam logic [paddr_width_p-1:0] hio_finish_addr_gp       = 40'h00_0010_2000;
  localparam logic [paddr_width_p-1:0] hio_putchar_core_addr_gp = 40'h00_0010_3000;
  localparam logic [paddr_width_p-1:0] hio_trace_en_addr_gp     = 40'h00_0010_4018;

endpackage
`default_nettype wire

// File: rtl/bp_host_io_initiator_cmd_encode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_hio_cmd_encode: combinational HIO op -> uncached io_cmd message mapping
// Revision: 1.0
// ----------------------------------------------------------------------------
module bp_hio_cmd_encode
  import bp_host_io_initiator_pkg::*;
#(
  parameter int core_id_width_p = 2
)
(
  input  logic [3:0]                      op_i,
  input  logic [core_id_width_p-1:0]      core_i,
  input  logic [hio_data_width_p-1:0]     data_i,
  output logic [cce_mem_msg_width_lp-1:0] msg_o,
  output logic                            is_read_o,
  output logic                            is_finish_o
);

  bp_bedrock_cce_mem_msg_s  msg;
  logic [paddr_width_p-1:0] core_offset;
  logic [3:0]               trace_k;

  assign core_offset = paddr_width_p'(core_i) << 3;
  assign trace_k     = op_i - 4'(e_hio_trace_en_0);

  always_comb begin
    msg                          = '0;
    msg.header.msg_type          = e_bedrock_mem_uc_wr;
    msg.header.size              = e_bedrock_msg_size_8;
    msg.data[hio_data_width_p-1:0] = data_i;
    case (op_i)
      e_hio_getchar: begin
        msg.header.msg_type = e_bedrock_mem_uc_rd;
        msg.header.addr     = hio_getchar_addr_gp;
      end
      e_hio_putchar:      msg.header.addr = hio_putchar_addr_gp;
      e_hio_finish:       msg.header.addr = hio_finish_addr_gp | core_offset;
      e_hio_putchar_core: msg.header.addr = hio_putchar_core_addr_gp | core_offset;
      default: begin
        // Codes above trace_en_9 are unmapped and leave the address at zero
        if (op_i <= 4'(e_hio_trace_en_9)) begin
          msg.header.addr = hio_trace_en_addr_gp + (paddr_width_p'(trace_k) << 3);
        end
      end
    endcase
  end

  assign msg_o       = msg;
  assign is_read_o   = (op_i == 4'(e_hio_getchar));
  assign is_finish_o = (op_i == 4'(e_hio_finish));

endmodule
`default_nettype wire

// File: rtl/bp_host_io_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_host_io_initiator: issues HIO io_cmds and checks in-order io_resps
// Revision: 1.0
// ----------------------------------------------------------------------------
module bp_host_io_initiator
  import bp_host_io_initiator_pkg::*;
#(
  parameter bp_params_e bp_params_p       = e_bp_default_cfg,
  parameter int         max_outstanding_p = 8,
  localparam int        num_core_lp       = cfg_num_core(bp_params_p),
  localparam int        core_id_width_lp  = (num_core_lp > 1) ? $clog2(num_core_lp) : 1
)
(
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            req_v_i,
  output logic                            req_ready_and_o,
  input  logic [3:0]                      req_op_i,
  input  logic [core_id_width_lp-1:0]     req_core_i,
  input  logic [hio_data_width_p-1:0]     req_data_i,
  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_and_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic                            resp_v_o,
  output logic [hio_data_width_p-1:0]     resp_data_o,
  input  logic                            resp_yumi_i,
  output logic                            credits_empty_o,
  output logic                            finish_sent_o,
  output logic                            error_o
);

  localparam int credit_width_lp = $clog2(max_outstanding_p + 1);
  localparam int ptr_width_lp    = $clog2(max_outstanding_p);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_outstanding_p);
  localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);
  localparam logic [ptr_width_lp-1:0]    last_ptr_lp    = ptr_width_lp'(max_outstanding_p - 1);
  localparam logic [ptr_width_lp-1:0]    one_ptr_lp     = ptr_width_lp'(1);

  typedef struct packed {
    logic [paddr_width_p-1:0] addr;
    logic                     is_read;
  } track_entry_s;

  logic [cce_mem_msg_width_lp-1:0] enc_msg_raw;
  bp_bedrock_cce_mem_msg_s         enc_msg, resp_msg, cmd_q, cmd_d;
  logic                            enc_is_read, enc_is_finish;
  logic                            cmd_v_q, cmd_v_d, cmd_finish_q, cmd_finish_d;
  logic [credit_width_lp-1:0]      credits_q, credits_d, count_q, count_d;
  logic [ptr_width_lp-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  track_entry_s                    fifo_mem_q [max_outstanding_p];
  track_entry_s                    fifo_mem_d [max_outstanding_p];
  track_entry_s                    head;
  logic                            resp_v_q, resp_v_d, finish_sent_q, finish_sent_d, error_q, error_d;
  logic [hio_data_width_p-1:0]     resp_data_q, resp_data_d;
  logic                            req_hs, cmd_hs, fifo_empty, fifo_full, resp_is_read, yumi;
  logic                            credit_dec, pop;
  logic                            unused_resp_bits;

  bp_hio_cmd_encode #(.core_id_width_p(core_id_width_lp)) encode (
    .op_i        (req_op_i),
    .core_i      (req_core_i),
    .data_i      (req_data_i),
    .msg_o       (enc_msg_raw),
    .is_read_o   (enc_is_read),
    .is_finish_o (enc_is_finish)
  );

  assign enc_msg      = enc_msg_raw;
  assign resp_msg     = io_resp_i;
  assign head         = fifo_mem_q[rptr_q];
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == max_credits_lp);
  assign resp_is_read = (resp_msg.header.msg_type == e_bedrock_mem_uc_rd);

  assign req_ready_and_o = (~cmd_v_q | io_cmd_ready_and_i) & (credits_q < max_credits_lp) & ~fifo_full;
  assign req_hs          = req_v_i & req_ready_and_o;
  assign cmd_hs          = cmd_v_q & io_cmd_ready_and_i;
  // Read data may only be taken when the single-entry return slot can accept it
  assign yumi            = io_resp_v_i & (~resp_is_read | ~resp_v_q | resp_yumi_i);
  assign credit_dec      = yumi & (credits_q != '0);
  assign pop             = yumi & ~fifo_empty;

  always_comb begin
    cmd_d        = req_hs ? enc_msg : cmd_q;
    cmd_finish_d = req_hs ? enc_is_finish : cmd_finish_q;
    cmd_v_d      = req_hs | (cmd_v_q & ~io_cmd_ready_and_i);

    credits_d = credits_q;
    if (cmd_hs & ~credit_dec) credits_d = credits_q + one_credit_lp;
    else if (~cmd_hs & credit_dec) credits_d = credits_q - one_credit_lp;

    fifo_mem_d = fifo_mem_q;
    if (req_hs) fifo_mem_d[wptr_q] = '{addr: enc_msg.header.addr, is_read: enc_is_read};
    wptr_d = req_hs ? ((wptr_q == last_ptr_lp) ? '0 : wptr_q + one_ptr_lp) : wptr_q;
    rptr_d = pop    ? ((rptr_q == last_ptr_lp) ? '0 : rptr_q + one_ptr_lp) : rptr_q;
    count_d = count_q;
    if (req_hs & ~pop) count_d = count_q + one_credit_lp;
    else if (~req_hs & pop) count_d = count_q - one_credit_lp;

    resp_v_d    = resp_v_q & ~resp_yumi_i;
    resp_data_d = resp_data_q;
    if (yumi & resp_is_read) begin
      resp_v_d    = 1'b1;
      resp_data_d = resp_msg.data[hio_data_width_p-1:0];
    end

    finish_sent_d = finish_sent_q | (cmd_hs & cmd_finish_q);
    error_d       = error_q | (yumi & (fifo_empty | (resp_msg.header.addr != head.addr)));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cmd_q         <= '0;
      cmd_v_q       <= 1'b0;
      cmd_finish_q  <= 1'b0;
      credits_q     <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      resp_v_q      <= 1'b0;
      resp_data_q   <= '0;
      finish_sent_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      cmd_q         <= cmd_d;
      cmd_v_q       <= cmd_v_d;
      cmd_finish_q  <= cmd_finish_d;
      credits_q     <= credits_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      resp_v_q      <= resp_v_d;
      resp_data_q   <= resp_data_d;
      finish_sent_q <= finish_sent_d;
      error_q       <= error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
  end

  credits_bound_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    credits_q <= max_credits_lp);

  assign io_cmd_o        = cmd_q;
  assign io_cmd_v_o      = cmd_v_q;
  assign io_resp_yumi_o  = yumi;
  assign resp_v_o        = resp_v_q;
  assign resp_data_o     = resp_data_q;
  assign credits_empty_o = (credits_q == '0) & ~cmd_v_q;
  assign finish_sent_o   = finish_sent_q;
  assign error_o         = error_q;

  assign unused_resp_bits = ^{resp_msg.data[cce_block_width_p-1:hio_data_width_p],
                              resp_msg.header.payload, resp_msg.header.size, head.is_read};

endmodule
`default_nettype wire

// File: tb/tb_bp_host_io_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bp_host_io_initiator: scoreboard bench for the HIO initiator
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bp_host_io_initiator;
  import bp_host_io_initiator_pkg::*;

  localparam int W = cce_mem_msg_width_lp;

  logic         clk_i = 1'b0;
  logic         reset_n_i, req_v_i, req_ready_and_o;
  logic [3:0]   req_op_i;
  logic [1:0]   req_core_i;
  logic [63:0]  req_data_i, resp_data_o;
  logic [W-1:0] io_cmd_o, io_resp_i;
  logic         io_cmd_v_o, io_cmd_ready_and_i, io_resp_v_i, io_resp_yumi_o;
  logic         resp_v_o, resp_yumi_i, credits_empty_o, finish_sent_o, error_o;

  always #5 clk_i = ~clk_i;

  bp_host_io_initiator #(.bp_params_p(e_bp_default_cfg), .max_outstanding_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_and_o(req_ready_and_o), .req_op_i(req_op_i),
    .req_core_i(req_core_i), .req_data_i(req_data_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .credits_empty_o(credits_empty_o), .finish_sent_o(finish_sent_o), .error_o(error_o)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  logic [W-1:0]             exp_cmd_q [$];
  logic [paddr_width_p-1:0] sent_addr_q [$];
  logic                     sent_rd_q [$];
  logic [63:0]              exp_data_q [$];
  bit                       rand_ready_en = 1'b0;
  logic                     cur_rd;
  logic [63:0]              cur_data;
  bp_bedrock_cce_mem_msg_s  mon_got, mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_msg(input logic [3:0] op, input logic [1:0] core,
                                           input logic [63:0] data);
    bp_bedrock_cce_mem_msg_s m;
    logic [paddr_width_p-1:0] a;
    case (op)
      4'd0:    a = 40'h0010_1000;
      4'd1:    a = 40'h0010_3000 | (40'(core) << 3);
      4'd2:    a = 40'h0010_0000;
      4'd3:    a = 40'h0010_2000 | (40'(core) << 3);
      default: a = 40'h0010_4018 + 40'(8 * (int'(op) - 4));
    endcase
    m = '0;
    m.header.addr     = a;
    m.header.msg_type = (op == 4'd2) ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
    m.header.size     = e_bedrock_msg_size_8;
    m.data[63:0]      = data;
    return m;
  endfunction

  // Monitors: commands leaving the DUT and getchar data being consumed
  always @(negedge clk_i) begin
    if (reset_n_i && io_cmd_v_o && io_cmd_ready_and_i) begin
      mon_got = io_cmd_o;
      if (exp_cmd_q.size() == 0) begin
        check("cmd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_cmd_q.pop_front();
        check("cmd_addr", 64'(mon_got.header.addr), 64'(mon_exp.header.addr));
        check("cmd_hdr", 64'({mon_got.header.msg_type, mon_got.header.size, mon_got.header.payload}),
              64'({mon_exp.header.msg_type, mon_exp.header.size, mon_exp.header.payload}));
        check("cmd_data_lo", mon_got.data[63:0], mon_exp.data[63:0]);
        check("cmd_data_hi", mon_got.data[127:64], mon_exp.data[127:64]);
      end
      sent_addr_q.push_back(mon_got.header.addr);
      sent_rd_q.push_back(mon_got.header.msg_type == e_bedrock_mem_uc_rd);
    end
    if (reset_n_i && resp_v_o && resp_yumi_i) begin
      if (exp_data_q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
      else check("resp_data", resp_data_o, exp_data_q.pop_front());
    end
  end

  always @(posedge clk_i) begin
    if (rand_ready_en) begin
      #1 io_cmd_ready_and_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_req(input logic [3:0] op, input logic [1:0] core, input logic [63:0] data);
    int n = 0;
    req_v_i = 1'b1; req_op_i = op; req_core_i = core; req_data_i = data;
    @(negedge clk_i);
    while (!req_ready_and_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (req_ready_and_o) exp_cmd_q.push_back(exp_msg(op, core, data));
    else check("req_timeout", 64'd0, 64'd1);
    step();
    req_v_i = 1'b0;
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (sent_addr_q.size() < n && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (sent_addr_q.size() < n) check("sent_timeout", 64'(sent_addr_q.size()), 64'(n));
    step();
  endtask

  task automatic present_resp(input logic [paddr_width_p-1:0] addr, input logic rd, input logic [63:0] data);
    bp_bedrock_cce_mem_msg_s m;
    m = '0;
    m.header.addr     = addr;
    m.header.msg_type = rd ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
    m.header.size     = e_bedrock_msg_size_8;
    m.data[63:0]      = data;
    io_resp_i = m; io_resp_v_i = 1'b1; cur_rd = rd; cur_data = data;
  endtask

  task automatic wait_resp_yumi();
    int n = 0;
    @(negedge clk_i);
    while (!io_resp_yumi_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (io_resp_yumi_o) begin
      if (cur_rd) exp_data_q.push_back(cur_data);
    end else begin
      check("resp_yumi_timeout", 64'd0, 64'd1);
    end
    step();
    io_resp_v_i = 1'b0;
  endtask

  task automatic host_resp_next(input logic [63:0] data);
    if (sent_addr_q.size() == 0) begin
      check("no_sent_cmd", 64'd0, 64'd1);
    end else begin
      present_resp(sent_addr_q.pop_front(), sent_rd_q.pop_front(), data);
      wait_resp_yumi();
    end
  endtask

  task automatic reset_assert();
    reset_n_i = 1'b0; req_v_i = 1'b0; io_resp_v_i = 1'b0;
    step();
    exp_cmd_q.delete(); sent_addr_q.delete(); sent_rd_q.delete(); exp_data_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_v"}, 64'(io_cmd_v_o), 64'd0);
    check({tag, "_resp_v"}, 64'(resp_v_o), 64'd0);
    check({tag, "_credits_empty"}, 64'(credits_empty_o), 64'd1);
    check({tag, "_finish"}, 64'(finish_sent_o), 64'd0);
    check({tag, "_error"}, 64'(error_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0; req_v_i = 1'b0; req_op_i = '0; req_core_i = '0; req_data_i = '0;
    io_cmd_ready_and_i = 1'b0; io_resp_i = '0; io_resp_v_i = 1'b0; resp_yumi_i = 1'b1;
    cur_rd = 1'b0; cur_data = '0;
    repeat (3) step();
    check_reset_state("rst");
    check("rst_req_ready", 64'(req_ready_and_o), 64'd1);
    reset_n_i = 1'b1;
    io_cmd_ready_and_i = 1'b1;
    step();

    // putchar 'A' and its write response
    send_req(e_hio_putchar, 2'd0, 64'h41);
    wait_sent(1);
    check("put_busy", 64'(credits_empty_o), 64'd0);
    host_resp_next(64'd0);
    repeat (2) step();
    check("put_empty", 64'(credits_empty_o), 64'd1);

    // getchar pair; second response must stall while resp_yumi_i is withheld
    resp_yumi_i = 1'b0;
    send_req(e_hio_getchar, 2'd0, 64'd0);
    send_req(e_hio_getchar, 2'd0, 64'd0);
    wait_sent(2);
    host_resp_next(64'h5A);
    check("getc_v", 64'(resp_v_o), 64'd1);
    check("getc_data", resp_data_o, 64'h5A);
    present_resp(sent_addr_q.pop_front(), sent_rd_q.pop_front(), 64'h33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("getc_stall_yumi", 64'(io_resp_yumi_o), 64'd0);
    end
    step();
    resp_yumi_i = 1'b1;
    wait_resp_yumi();
    repeat (2) step();
    check("getc_drained", 64'(resp_v_o), 64'd0);

    // fill all credits, then one response frees exactly one slot
    for (int i = 0; i < 8; i++) send_req(e_hio_putchar, 2'd0, 64'(i));
    @(negedge clk_i);
    check("full_ready", 64'(req_ready_and_o), 64'd0);
    step();
    wait_sent(8);
    @(negedge clk_i);
    check("full_ready_sent", 64'(req_ready_and_o), 64'd0);
    step();
    host_resp_next(64'd0);
    @(negedge clk_i);
    check("ready_after_resp", 64'(req_ready_and_o), 64'd1);
    step();
    send_req(e_hio_putchar, 2'd0, 64'h99);
    @(negedge clk_i);
    check("full_again", 64'(req_ready_and_o), 64'd0);
    step();
    wait_sent(8);
    for (int i = 0; i < 8; i++) host_resp_next(64'd0);
    repeat (2) step();
    check("full_drained", 64'(credits_empty_o), 64'd1);

    // finish core 1, trace enables and putchar_core
    send_req(e_hio_finish, 2'd1, 64'd0);
    wait_sent(1);
    check("finish_sent", 64'(finish_sent_o), 64'd1);
    host_resp_next(64'd0);
    send_req(e_hio_trace_en_3, 2'd0, 64'd1);
    send_req(e_hio_putchar_core, 2'd2, 64'h42);
    send_req(e_hio_trace_en_9, 2'd0, 64'd1);
    wait_sent(3);
    for (int i = 0; i < 3; i++) host_resp_next(64'd0);
    repeat (3) step();
    check("finish_sticky", 64'(finish_sent_o), 64'd1);
    check("no_error_yet", 64'(error_o), 64'd0);

    // address mismatch, then stray response with nothing outstanding
    send_req(e_hio_putchar, 2'd0, 64'h45);
    wait_sent(1);
    void'(sent_addr_q.pop_front());
    void'(sent_rd_q.pop_front());
    present_resp(40'h0010_0000, 1'b0, 64'd0);
    wait_resp_yumi();
    check("err_mismatch", 64'(error_o), 64'd1);
    repeat (2) step();
    check("err_sticky", 64'(error_o), 64'd1);
    reset_assert();
    check("err_rst", 64'(error_o), 64'd0);
    reset_n_i = 1'b1;
    step();
    present_resp(40'h0010_1000, 1'b0, 64'd0);
    wait_resp_yumi();
    check("err_stray", 64'(error_o), 64'd1);

    // random backpressure with ordering, then reset mid-burst
    rand_ready_en = 1'b1;
    for (int i = 0; i < 6; i++) send_req(e_hio_putchar, 2'd0, 64'h60 + 64'(i));
    wait_sent(6);
    for (int i = 0; i < 6; i++) host_resp_next(64'd0);
    for (int i = 0; i < 4; i++) send_req(e_hio_putchar_core, 2'(i), 64'h70 + 64'(i));
    rand_ready_en = 1'b0;
    reset_assert();
    check_reset_state("midrst");
    io_cmd_ready_and_i = 1'b1;
    reset_n_i = 1'b1;
    step();
    send_req(e_hio_putchar, 2'd0, 64'h5B);
    wait_sent(1);
    host_resp_next(64'd0);
    repeat (2) step();
    check("post_rst_empty", 64'(credits_empty_o), 64'd1);
    check("post_rst_error", 64'(error_o), 64'd0);
    check("scoreboard_left", 64'(exp_cmd_q.size() + exp_data_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
